// File: rtl/dut_sched_pkg.sv
// Shared types and constants for the dut_sched round-robin scheduler.
// Optional statistics are enabled with the DUT_SCHED_STATS_EN macro (see dut_sched.sv).
package dut_sched_pkg;

    localparam int DIN_W  = 8;
    localparam int DOUT_W = 32;
    localparam int OPS    = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // Ceiling log2, never less than one bit, used to size requester tags.
    function automatic int tag_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dut_sched_tagq.sv
// In-order FIFO of requester tags for results still owed by the shared dut.
// Combinational head; count, empty and full all come from the registered count.
module dut_sched_tagq #(
    parameter int DEPTH = 8,
    parameter int W     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_tag,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Tag storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_tag;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign empty = (count_r == {CW{1'b0}});
    assign full  = (count_r == CW'(DEPTH));
    assign count = count_r;

endmodule

// File: rtl/dut_sched.sv
// Round-robin scheduler sharing one pipelined dut between N_REQ requesters.
// Define DUT_SCHED_STATS_EN to add per-requester grant counters and a full-stall counter.
module dut_sched
    import dut_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef DUT_SCHED_STATS_EN
    output logic [N_REQ*16-1:0]          stat_grants,
    output logic [15:0]                  stat_full_cycles,
`endif
    input  logic [N_REQ-1:0]             req_vld,
    output logic [N_REQ-1:0]             req_busy,
    input  logic [N_REQ*OPS*DIN_W-1:0]   req_data,
    output logic                         din_vld,
    input  logic                         din_busy,
    output logic [DIN_W-1:0]             din_data_a,
    output logic [DIN_W-1:0]             din_data_b,
    output logic [DIN_W-1:0]             din_data_c,
    output logic [DIN_W-1:0]             din_data_d,
    output logic [DIN_W-1:0]             din_data_e,
    output logic [DIN_W-1:0]             din_data_f,
    output logic [DIN_W-1:0]             din_data_g,
    output logic [DIN_W-1:0]             din_data_h,
    input  logic                         dout_vld,
    output logic                         dout_busy,
    input  logic [DOUT_W-1:0]            dout_data,
    output logic [N_REQ-1:0]             rsp_vld,
    input  logic [N_REQ-1:0]             rsp_busy,
    output logic [DOUT_W-1:0]            rsp_data
);

    localparam int TW  = tag_width(N_REQ);
    localparam int OPW = OPS * DIN_W;
    localparam int CW  = $clog2(TAG_DEPTH) + 1;

    state_t         state_r;
    logic [TW-1:0]  rr_ptr_r;
    logic [OPW-1:0] op_r;

    logic [TW-1:0]  winner_s;
    logic [TW:0]    cand_s;
    logic           found_s;
    logic           permit_s;
    logic           capture_s;
    logic [TW-1:0]  next_ptr_s;
    logic [TW-1:0]  head_s;
    logic           empty_s;
    logic           full_s;
    logic [CW-1:0]  count_s;
    logic           pop_s;

    // Round-robin search starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        winner_s = rr_ptr_r;
        found_s  = 1'b0;
        cand_s   = {(TW+1){1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = {1'b0, rr_ptr_r} + (TW+1)'(k);
            if (cand_s >= (TW+1)'(N_REQ)) begin
                cand_s = cand_s - (TW+1)'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req_vld[cand_s[TW-1:0]]) begin
                found_s  = 1'b1;
                winner_s = cand_s[TW-1:0];
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Full uses the registered count, so a same-cycle pop does not open a slot.
    assign permit_s   = ((state_r == IDLE) || !din_busy) && !full_s && !rst;
    assign capture_s  = permit_s && found_s;
    assign next_ptr_s = (winner_s == TW'(N_REQ - 1)) ? {TW{1'b0}} : (winner_s + TW'(1));

    // Only the winner of a capture-permitted cycle sees itself ready.
    always_comb begin
        req_busy = {N_REQ{1'b1}};
        if (capture_s) begin
            req_busy[winner_s] = 1'b0;
        end else begin
            req_busy = {N_REQ{1'b1}};
        end
    end

    // Operand register FSM; a capture in OFFER overlaps the dut accepting the previous set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            rr_ptr_r <= {TW{1'b0}};
            op_r     <= {OPW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (capture_s) begin
                        state_r  <= OFFER;
                        rr_ptr_r <= next_ptr_s;
                        op_r     <= req_data[int'(winner_s)*OPW +: OPW];
                    end
                end
                OFFER: begin
                    if (capture_s) begin
                        state_r  <= OFFER;
                        rr_ptr_r <= next_ptr_s;
                        op_r     <= req_data[int'(winner_s)*OPW +: OPW];
                    end else if (!din_busy) begin
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign din_vld    = (state_r == OFFER);
    assign din_data_a = op_r[7:0];
    assign din_data_b = op_r[15:8];
    assign din_data_c = op_r[23:16];
    assign din_data_d = op_r[31:24];
    assign din_data_e = op_r[39:32];
    assign din_data_f = op_r[47:40];
    assign din_data_g = op_r[55:48];
    assign din_data_h = op_r[63:56];

    dut_sched_tagq #(
        .DEPTH (TAG_DEPTH),
        .W     (TW)
    ) u_tagq (
        .clk      (clk),
        .rst      (rst),
        .push     (capture_s),
        .push_tag (winner_s),
        .pop      (pop_s),
        .head     (head_s),
        .empty    (empty_s),
        .full     (full_s),
        .count    (count_s)
    );

    // Results return in issue order, so the queue head names the owner.
    always_comb begin
        rsp_vld = {N_REQ{1'b0}};
        if (dout_vld && !empty_s) begin
            rsp_vld[head_s] = 1'b1;
        end else begin
            rsp_vld = {N_REQ{1'b0}};
        end
    end

    assign dout_busy = empty_s || rsp_busy[head_s];
    assign pop_s     = dout_vld && !dout_busy;
    assign rsp_data  = dout_data;

`ifdef DUT_SCHED_STATS_EN
    logic [15:0] grants_r [N_REQ];
    logic [15:0] full_cyc_r;

    // Saturating grant and full-stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                grants_r[i] <= 16'd0;
            end
            full_cyc_r <= 16'd0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (capture_s && (winner_s == TW'(i)) && (grants_r[i] != 16'hFFFF)) begin
                    grants_r[i] <= grants_r[i] + 16'd1;
                end
            end
            if ((|req_vld) && full_s && (full_cyc_r != 16'hFFFF)) begin
                full_cyc_r <= full_cyc_r + 16'd1;
            end
        end
    end

    // Flatten grant counters onto the stats bus.
    always_comb begin
        stat_grants = {(N_REQ*16){1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            stat_grants[i*16 +: 16] = grants_r[i];
        end
    end

    assign stat_full_cycles = full_cyc_r;
`endif

endmodule

// File: tb/tb_dut_sched.sv
// Directed bench for dut_sched: a 4-requester/8-deep instance for arbitration and
// routing, plus a 2-deep instance for the full-queue boundary.
module tb_dut_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance (TAG_DEPTH=8)
    logic [3:0]   req_vld, req_busy, rsp_vld, rsp_busy;
    logic [255:0] req_data;
    logic         din_vld, din_busy, dout_vld, dout_busy;
    logic [7:0]   da, db, dc, dd, de, df, dg, dh;
    logic [31:0]  dout_data, rsp_data;
    logic [63:0]  din_bus;
    assign din_bus = {dh, dg, df, de, dd, dc, db, da};

    // Small instance (TAG_DEPTH=2)
    logic [3:0]   s_req_vld, s_req_busy, s_rsp_vld, s_rsp_busy;
    logic [255:0] s_req_data;
    logic         s_din_vld, s_din_busy, s_dout_vld, s_dout_busy;
    logic [7:0]   sa, sb, sc, sd, se, sf, sg, sh;
    logic [31:0]  s_dout_data, s_rsp_data;

`ifdef DUT_SCHED_STATS_EN
    logic [63:0]  stat_grants, s_stat_grants;
    logic [15:0]  stat_full_cycles, s_stat_full_cycles;
`endif

    dut_sched #(.N_REQ(4), .TAG_DEPTH(8)) u_dut (
        .clk(clk), .rst(rst),
`ifdef DUT_SCHED_STATS_EN
        .stat_grants(stat_grants), .stat_full_cycles(stat_full_cycles),
`endif
        .req_vld(req_vld), .req_busy(req_busy), .req_data(req_data),
        .din_vld(din_vld), .din_busy(din_busy),
        .din_data_a(da), .din_data_b(db), .din_data_c(dc), .din_data_d(dd),
        .din_data_e(de), .din_data_f(df), .din_data_g(dg), .din_data_h(dh),
        .dout_vld(dout_vld), .dout_busy(dout_busy), .dout_data(dout_data),
        .rsp_vld(rsp_vld), .rsp_busy(rsp_busy), .rsp_data(rsp_data)
    );

    dut_sched #(.N_REQ(4), .TAG_DEPTH(2)) u_small (
        .clk(clk), .rst(rst),
`ifdef DUT_SCHED_STATS_EN
        .stat_grants(s_stat_grants), .stat_full_cycles(s_stat_full_cycles),
`endif
        .req_vld(s_req_vld), .req_busy(s_req_busy), .req_data(s_req_data),
        .din_vld(s_din_vld), .din_busy(s_din_busy),
        .din_data_a(sa), .din_data_b(sb), .din_data_c(sc), .din_data_d(sd),
        .din_data_e(se), .din_data_f(sf), .din_data_g(sg), .din_data_h(sh),
        .dout_vld(s_dout_vld), .dout_busy(s_dout_busy), .dout_data(s_dout_data),
        .rsp_vld(s_rsp_vld), .rsp_busy(s_rsp_busy), .rsp_data(s_rsp_data)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] pat [4];
    int order [5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            pat[i] = 64'h1716151413121110 + 64'(i) * 64'h1010101010101010;
        end
        rst = 1'b1;
        req_vld = 4'd0; req_data = 256'd0; din_busy = 1'b0;
        dout_vld = 1'b0; dout_data = 32'd0; rsp_busy = 4'd0;
        s_req_vld = 4'd0; s_req_data = 256'd0; s_din_busy = 1'b0;
        s_dout_vld = 1'b0; s_dout_data = 32'd0; s_rsp_busy = 4'd0;
        tick; tick;

        // Reset values, with requests present while rst is held
        req_vld = 4'hF;
        settle;
        chk("rst_din_vld", 64'(din_vld), 64'd0);
        chk("rst_din_data", din_bus, 64'd0);
        chk("rst_req_busy", 64'(req_busy), 64'hF);
        chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("rst_dout_busy", 64'(dout_busy), 64'd1);
        req_vld = 4'd0;
        rst = 1'b0;
        settle;
        chk("idle_req_busy", 64'(req_busy), 64'hF);

        // Single requester 2, bytes 1..8, result 0x24
        req_data[2*64 +: 64] = 64'h0807060504030201;
        req_vld = 4'b0100;
        settle;
        chk("t1_req_busy", 64'(req_busy), 64'hB);
        tick;
        req_vld = 4'd0;
        chk("t1_din_vld", 64'(din_vld), 64'd1);
        chk("t1_din_data", din_bus, 64'h0807060504030201);
        tick;
        chk("t1_din_vld_drop", 64'(din_vld), 64'd0);
        dout_vld = 1'b1; dout_data = 32'h24;
        settle;
        chk("t1_rsp_vld", 64'(rsp_vld), 64'h4);
        chk("t1_rsp_data", 64'(rsp_data), 64'h24);
        chk("t1_dout_busy", 64'(dout_busy), 64'd0);
        tick;
        chk("empty_dout_busy", 64'(dout_busy), 64'd1);
        chk("empty_rsp_vld", 64'(rsp_vld), 64'd0);
        dout_vld = 1'b0;

        // All four requesting from rr_ptr=0: order 0,1,2,3,0
        rst = 1'b1;
        tick;
        rst = 1'b0;
        req_data = {pat[3], pat[2], pat[1], pat[0]};
        req_vld = 4'hF;
        for (int k = 0; k < 5; k++) begin
            settle;
            chk($sformatf("rr_req_busy%0d", k), 64'(req_busy), 64'(4'hF & ~(4'd1 << order[k])));
            tick;
            chk($sformatf("rr_din%0d", k), din_bus, pat[order[k]]);
        end
        req_vld = 4'd0;
        for (int k = 0; k < 5; k++) begin
            dout_vld = 1'b1; dout_data = 32'h100 + 32'(k);
            settle;
            chk($sformatf("rr_rsp_vld%0d", k), 64'(rsp_vld), 64'(4'd1 << order[k]));
            chk($sformatf("rr_rsp_data%0d", k), 64'(rsp_data), 64'h100 + 64'(k));
            tick;
        end
        dout_vld = 1'b0;

        // din_busy stall: rr_ptr=1, requester 1 captured, then held 5 cycles
        req_vld = 4'b0010;
        settle;
        chk("st_req_busy0", 64'(req_busy), 64'hD);
        tick;
        din_busy = 1'b1;
        req_vld = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            settle;
            chk($sformatf("st_busy%0d", k), 64'(req_busy), 64'hF);
            tick;
            chk($sformatf("st_hold%0d", k), {din_bus[62:0], din_vld}, {pat[1][62:0], 1'b1});
        end
        din_busy = 1'b0;
        settle;
        chk("st_release_busy", 64'(req_busy), 64'h7);
        tick;
        req_vld = 4'd0;
        chk("st_new_din", din_bus, pat[3]);
        tick;

        // rsp_busy on head (tag 1), then tag 3 follows
        dout_vld = 1'b1; dout_data = 32'h55; rsp_busy = 4'b0010;
        settle;
        chk("rb_dout_busy", 64'(dout_busy), 64'd1);
        chk("rb_rsp_vld", 64'(rsp_vld), 64'h2);
        tick;
        chk("rb_no_pop", 64'(rsp_vld), 64'h2);
        rsp_busy = 4'd0;
        settle;
        chk("rb_release", 64'(dout_busy), 64'd0);
        tick;
        dout_data = 32'h66;
        settle;
        chk("rb_next_head", 64'(rsp_vld), 64'h8);
        chk("rb_next_data", 64'(rsp_data), 64'h66);
        tick;
        dout_vld = 1'b0;

        // Reset in OFFER with 3 outstanding (rr_ptr=0 -> captures 0,1,2)
        req_vld = 4'b0111;
        tick; tick; tick;
        req_vld = 4'd0; din_busy = 1'b1;
        chk("pre_rst_offer", 64'(din_vld), 64'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0; din_busy = 1'b0; dout_vld = 1'b1;
        settle;
        chk("mr_din_vld", 64'(din_vld), 64'd0);
        chk("mr_din_data", din_bus, 64'd0);
        chk("mr_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("mr_dout_busy", 64'(dout_busy), 64'd1);
`ifdef DUT_SCHED_STATS_EN
        chk("mr_stat_grants", stat_grants, 64'd0);
`endif
        dout_vld = 1'b0;
        req_vld = 4'b1010;
        settle;
        chk("mr_rr_ptr0", 64'(req_busy), 64'hD);
        tick;
        req_vld = 4'd0;
        chk("mr_din_after", din_bus, pat[1]);
`ifdef DUT_SCHED_STATS_EN
        chk("mr_stat_inc", stat_grants, 64'h0000_0000_0001_0000);
`endif
        tick;

        // Small instance: TAG_DEPTH=2 full boundary
        s_req_data = {pat[3], pat[2], pat[1], pat[0]};
        s_req_vld = 4'b0001;
        settle;
        chk("fu_cap0", 64'(s_req_busy), 64'hE);
        tick;
        settle;
        chk("fu_cap1", 64'(s_req_busy), 64'hE);
        tick;
        settle;
        chk("fu_blocked", 64'(s_req_busy), 64'hF);
        tick;
        s_dout_vld = 1'b1; s_dout_data = 32'h77; s_rsp_busy = 4'b0001;
        settle;
        chk("fu_stall_dout_busy", 64'(s_dout_busy), 64'd1);
        chk("fu_stall_req_busy", 64'(s_req_busy), 64'hF);
        tick;
        s_rsp_busy = 4'd0;
        settle;
        chk("fu_pop_dout_busy", 64'(s_dout_busy), 64'd0);
        chk("fu_pop_same_cycle", 64'(s_req_busy), 64'hF);
        tick;
        s_dout_vld = 1'b0;
`ifdef DUT_SCHED_STATS_EN
        chk("fu_stat_full", 64'(s_stat_full_cycles), 64'd3);
        chk("fu_stat_grants", s_stat_grants, 64'd2);
`endif
        settle;
        chk("fu_after_pop", 64'(s_req_busy), 64'hE);
        tick;
        s_req_vld = 4'd0;
        chk("fu_din_vld", 64'(s_din_vld), 64'd1);
        chk("fu_din_data", {sh, sg, sf, se, sd, sc, sb, sa}, pat[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dut_sched.md
# dut_sched

Round-robin scheduler that shares one pipelined `dut` datapath (eight 8-bit operands in, one 32-bit result out, vld/busy handshakes) between N_REQ independent requesters. It arbitrates input transactions, registers the winning operand set onto the DUT input port, records the winner's index in an in-order tag queue, and routes each DUT result back to the requester that issued it. It sits between the requester channels and the `dut` instance inside the cosim wrapper.

## Interface
- N_REQ, 4, number of requesters (2..8)
- TAG_DEPTH, 8, max outstanding transactions (power of 2, ≥2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_vld  in  N_REQ  per-requester operand valid
- req_busy  out  N_REQ  per-requester not-ready
- req_data  in  N_REQ*64  operand sets; requester i at [64i+63:64i], byte a at [7:0] … h at [63:56]
- din_vld  out  1  to dut
- din_busy  in  1  from dut
- din_data_a … din_data_h  out  8 each  to dut
- dout_vld  in  1  from dut
- dout_busy  out  1  to dut
- dout_data  in  32  from dut
- rsp_vld  out  N_REQ  per-requester result valid
- rsp_busy  in  N_REQ  per-requester not-ready
- rsp_data  out  32  shared result bus

## Operation
- Transfer on any channel = vld && !busy in the same cycle.
- States: IDLE (no held operand), OFFER (operand register driving din_*, din_vld=1).
- Capture permitted when state==IDLE, or state==OFFER && !din_busy, and registered count < TAG_DEPTH.
- Winner = first i with req_vld[i] searching rr_ptr, rr_ptr+1, … mod N_REQ. req_busy[i]=0 only for the winner in a capture-permitted cycle; all others 1.
- On capture: req_data slice → operand register, winner index pushed to tag queue, rr_ptr ← winner+1 mod N_REQ, state → OFFER.
- OFFER && !din_busy && no capture → IDLE. OFFER && din_busy → hold; din_* stable.
- Response path combinational: head = tag queue head. rsp_vld[head]=dout_vld && !empty; other rsp_vld=0; rsp_data=dout_data; dout_busy = empty || rsp_busy[head]. Pop on response transfer.
- Count: +1 on capture, −1 on pop, unchanged when both occur. Full check uses the registered count, so a capture in a cycle with a pop at count==TAG_DEPTH is still blocked.
- dout_vld while empty: ignored (dout_busy=1), not an error output.

## Timing
- Reset values: din_vld=0, din_data_*=0, req_busy=all 1, rsp_vld=0, dout_busy=1, rr_ptr=0, count=0, state=IDLE.
- Requester capture → din_vld next cycle (1-cycle latency). Back-to-back issue sustained 1 per cycle while din_busy=0.
- dout → rsp: 0 cycles (combinational).
- Reset mid-operation: operand register and tag queue discarded; in-flight DUT results after reset are held off by dout_busy=1 (the DUT is reset with the same rst).

## Configuration
- DUT_SCHED_STATS_EN defined: adds output stat_grants (N_REQ*16), a per-requester 16-bit saturating capture counter, and stat_full_cycles (16, saturating), counting cycles with any req_vld while count==TAG_DEPTH. All are cleared by rst.
- Undefined: stat ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package dut_sched_pkg: DIN_W=8, DOUT_W=32, OPS=8, state enum {IDLE, OFFER}, tag width function clog2(N_REQ).
- Sub-module dut_sched_tagq: synchronous FIFO of tags, TAG_DEPTH entries, push/pop/empty/full/count, with a combinational head.

## Test plan
- Single requester 2 sends a=1…h=8, din_busy=0 → din_vld next cycle with bytes 1…8. Result 0x24 → rsp_vld[2] only, rsp_data=0x24.
- All four req_vld held high, din_busy=0 → captures in order 0,1,2,3,0. In-order DUT results route to rsp_vld 0,1,2,3.
- din_busy=1 for 5 cycles in OFFER → din_* stable, no capture, req_busy all 1. Release → transfer, new capture same cycle.
- TAG_DEPTH=2, dout_busy stalled by rsp_busy → third request blocked (req_busy=1) until one pop; simultaneous pop+capture at full is blocked for one cycle.
- rsp_busy[head]=1 with dout_vld=1 → dout_busy=1 and no pop. Deassert → pop; the next head routes correctly.
- rst pulsed in OFFER with 3 outstanding → next cycle all outputs at reset values, count=0. With DUT_SCHED_STATS_EN, the counters read 0 and then increment per capture.
